// File: rtl/nf2401_cfg_master_if.sv
// Avalon-MM bus between the serial config master and its 3-bit PIO slave
// (bit0 = DATA, bit1 = CLK, bit2 = CS).
interface nf2401_cfg_master_if;
  logic [1:0] avm_address;
  logic       avm_chipselect;
  logic       avm_write_n;
  logic [2:0] avm_writedata;
  logic [2:0] avm_readdata;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/nf2401_cfg_master.sv
// Bit-banged serial config master driving a PIO slave over Avalon-MM.
// Define NF2401_READBACK_EN to enable read transfers (DATA released and sampled).
module nf2401_cfg_master #(
  parameter int HALF_PERIOD = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [31:0]               tx_word,
  input  logic [5:0]                nbits,
  input  logic                      rd_mode,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               rx_word,
  nf2401_cfg_master_if.master       avm
);

  localparam logic [7:0] HOLD_LAST = 8'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DIR, S_LO, S_HI, S_END, S_REL, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] tx_q, tx_d;
  logic [5:0]  nb_q, nb_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  idx;
  logic        cur_bit;
  logic        rd_eff;
  logic [1:0]  addr_c;
  logic        cs_c;
  logic [2:0]  wd_c;
  logic        done_c;

`ifdef NF2401_READBACK_EN
  logic        rd_q, rd_d;
  logic [31:0] rx_q, rx_d;
  logic        unused_readdata;
  assign rd_eff          = rd_q;
  assign rx_word         = rx_q;
  assign unused_readdata = ^avm.avm_readdata[2:1];
`else
  logic        unused_inputs;
  assign rd_eff        = 1'b0;
  assign rx_word       = '0;
  assign unused_inputs = ^{rd_mode, avm.avm_readdata};
`endif

  // nb_q counts bits still to send, so the current bit sits at nb_q-1
  assign idx     = 5'(nb_q - 6'd1);
  assign cur_bit = tx_q[idx];

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    nb_d    = nb_q;
    cnt_d   = cnt_q;
`ifdef NF2401_READBACK_EN
    rd_d    = rd_q;
    rx_d    = rx_q;
`endif
    addr_c  = 2'd0;
    cs_c    = 1'b0;
    wd_c    = 3'b000;
    done_c  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        done_c  = (state_q == S_DONE);
        state_d = S_IDLE;
        if (start) begin
          state_d = S_DIR;
          tx_d    = tx_word;
          nb_d    = (nbits > 6'd32) ? 6'd32 : nbits;
          cnt_d   = 8'd0;
`ifdef NF2401_READBACK_EN
          rd_d    = rd_mode;
          rx_d    = '0;
`endif
        end
      end
      S_DIR: begin
        cs_c    = 1'b1;
        addr_c  = 2'd1;
        wd_c    = rd_eff ? 3'b110 : 3'b111;
        cnt_d   = 8'd0;
        state_d = (nb_q == 6'd0) ? S_END : S_LO;
      end
      S_LO: begin
        cs_c = (cnt_q == 8'd0);
        wd_c = {2'b10, cur_bit};
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_HI;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HI: begin
        cs_c = (cnt_q == 8'd0);
        wd_c = {2'b11, cur_bit & ~rd_eff};
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = 8'd0;
          nb_d    = nb_q - 6'd1;
          state_d = (nb_q == 6'd1) ? S_END : S_LO;
`ifdef NF2401_READBACK_EN
          // readdata reflects the pin one cycle late, long settled by now
          if (rd_q) rx_d = {rx_q[30:0], avm.avm_readdata[0]};
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_END: begin
        cs_c    = 1'b1;
        state_d = S_REL;
      end
      S_REL: begin
        cs_c    = 1'b1;
        addr_c  = 2'd1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!cs_c) begin
      addr_c = 2'd0;
      wd_c   = 3'b000;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tx_q    <= '0;
      nb_q    <= '0;
      cnt_q   <= '0;
`ifdef NF2401_READBACK_EN
      rd_q    <= 1'b0;
      rx_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      nb_q    <= nb_d;
      cnt_q   <= cnt_d;
`ifdef NF2401_READBACK_EN
      rd_q    <= rd_d;
      rx_q    <= rx_d;
`endif
    end
  end

  assign busy               = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done               = done_c;
  assign avm.avm_address    = addr_c;
  assign avm.avm_chipselect = cs_c;
  assign avm.avm_write_n    = ~cs_c;
  assign avm.avm_writedata  = wd_c;

endmodule

// File: tb/tb_nf2401_cfg_master.sv
// Randomized bench for nf2401_cfg_master: PIO slave + serial device model,
// expected bus write sequence and timing derived from the transfer rules.
module tb_nf2401_cfg_master;
  localparam int HP = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] tx_word = '0;
  logic [5:0]  nbits = '0;
  logic        rd_mode = 1'b0;
  logic        busy, done;
  logic [31:0] rx_word;

  nf2401_cfg_master_if bus();

  nf2401_cfg_master #(.HALF_PERIOD(HP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .tx_word (tx_word),
    .nbits   (nbits),
    .rd_mode (rd_mode),
    .busy    (busy),
    .done    (done),
    .rx_word (rx_word),
    .avm     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: log every write, flag any non-idle value outside a write
  logic [4:0] wq[$];
  int done_cnt = 0;
  int idle_bad = 0;

  always @(negedge clk) begin
    if (bus.avm_chipselect === 1'b1 && bus.avm_write_n === 1'b0)
      wq.push_back({bus.avm_address, bus.avm_writedata});
    else if (bus.avm_chipselect !== 1'b0 || bus.avm_write_n !== 1'b1 || bus.avm_address !== 2'b00)
      idle_bad <= idle_bad + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // PIO slave with registered readdata; external device shifts pattern MSB-first,
  // presenting a new bit after each falling serial clock
  logic [2:0]  dir_reg, out_reg;
  int          lo_cnt;
  logic [31:0] pat = '0;
  int          exp_n = 0;
  logic        dev_bit;

  always_comb dev_bit = (lo_cnt >= 1 && lo_cnt <= exp_n) ? pat[exp_n - lo_cnt] : 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_reg          <= '0;
      out_reg          <= '0;
      lo_cnt           <= 0;
      bus.avm_readdata <= '0;
    end else begin
      bus.avm_readdata <= {out_reg[2:1], dir_reg[0] ? out_reg[0] : dev_bit};
      if (bus.avm_chipselect && !bus.avm_write_n) begin
        if (bus.avm_address == 2'd1) begin
          dir_reg <= bus.avm_writedata;
          lo_cnt  <= 0;
        end else begin
          out_reg <= bus.avm_writedata;
          if (bus.avm_writedata[2:1] == 2'b10) lo_cnt <= lo_cnt + 1;
        end
      end
    end
  end

  task automatic run_xfer(input logic [31:0] tw, input logic [5:0] nb, input logic rm,
                          input logic [31:0] pt, input int glitch_at, input int rst_at);
    int          n, base, dbase, cyc, exp_done, limit;
    logic        eff_rd;
    logic [4:0]  exp_q[$];
    logic [63:0] m;
    logic [31:0] exp_rx;
    n = (nb > 6'd32) ? 32 : int'(nb);
`ifdef NF2401_READBACK_EN
    eff_rd = rm;
`else
    eff_rd = 1'b0;
`endif
    exp_q.push_back({2'd1, eff_rd ? 3'b110 : 3'b111});
    for (int i = n - 1; i >= 0; i--) begin
      exp_q.push_back({2'd0, 2'b10, tw[i]});
      exp_q.push_back({2'd0, 2'b11, eff_rd ? 1'b0 : tw[i]});
    end
    exp_q.push_back({2'd0, 3'b000});
    exp_q.push_back({2'd1, 3'b000});
    m        = (64'd1 << n) - 64'd1;
    exp_rx   = eff_rd ? (pt & m[31:0]) : 32'd0;
    exp_done = 3 + 2 * HP * n;
    limit    = exp_done + 20;
    pat      = pt;
    exp_n    = n;

    @(negedge clk);
    base    = wq.size();
    dbase   = done_cnt;
    start   = 1'b1;
    tx_word = tw;
    nbits   = nb;
    rd_mode = rm;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    tx_word = $urandom;
    nbits   = 6'($urandom);
    rd_mode = 1'($urandom);
    check("busy_after_start", busy, 1);

    cyc = 0;
    while (done !== 1'b1 && cyc < limit) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = (cyc == glitch_at);
      if (cyc == rst_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx", rx_word, 0);
        check("rst_cs", bus.avm_chipselect, 0);
        check("rst_wn", bus.avm_write_n, 1);
        check("rst_addr", bus.avm_address, 0);
        check("rst_wdata", bus.avm_writedata, 0);
        #2 reset_n = 1'b1;
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
    check("done_cycle", cyc, exp_done);
    check("busy_at_done", busy, 0);
    check("rx_at_done", rx_word, exp_rx);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    @(negedge clk);
    check("rx_hold", rx_word, exp_rx);
    check("done_pulses", done_cnt - dbase, 1);
    check("n_writes", wq.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < wq.size(); i++)
      check($sformatf("wr%0d", i), wq[base + i], exp_q[i]);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rx", rx_word, 0);
    check("reset_cs", bus.avm_chipselect, 0);
    check("reset_wn", bus.avm_write_n, 1);
    check("reset_addr", bus.avm_address, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(32'h0000_00A5, 6'd8, 1'b0, 32'h0, -1, -1);
    run_xfer(32'h0000_0000, 6'd8, 1'b1, 32'h0000_003C, -1, -1);
    run_xfer(32'h1234_5678, 6'd12, 1'b0, 32'h0, 10, -1);
    run_xfer(32'hFFFF_FFFF, 6'd40, 1'b0, 32'h0, -1, -1);
    run_xfer(32'hDEAD_BEEF, 6'd0, 1'b0, 32'h0, -1, -1);
    run_xfer(32'h0F0F_0F0F, 6'd16, 1'b1, 32'hAAAA_5555, -1, 20);
    run_xfer(32'h0000_0C3A, 6'd12, 1'b0, 32'h0, -1, -1);

    for (int k = 0; k < 20; k++) begin
      logic [5:0] nb;
      nb = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(33, 63)) : 6'($urandom_range(0, 12));
      run_xfer($urandom, nb, 1'($urandom), $urandom, -1, -1);
    end

    check("bus_idle_values", idle_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
